// File: rtl/reg_file_rw_if.sv
// Register-map identifiers plus the bundled port interface of the register file.
// reg_map_pkg: reg_id_t encodings (real ids 0..19, fake ids 0x80..0x85) and reg_val_t layout.
// reg_file_rw_if: read ports, write-back, scoreboard mark, error pulse and dump stream.

package reg_map_pkg;

    typedef logic [7:0] reg_id_t;

    // Flags sit above the value: bit 69 = cf ... bit 64 = af.
    typedef struct packed {
        logic        cf;
        logic        zf;
        logic        sf;
        logic        of;
        logic        pf;
        logic        af;
        logic [63:0] val;
    } reg_val_t;

    // Real registers: reg_num(id) == id[4:0].
    localparam reg_id_t RAX      = 8'h00;
    localparam reg_id_t RBX      = 8'h03;
    localparam reg_id_t RSP      = 8'h04;
    localparam reg_id_t R12      = 8'h0C;
    localparam reg_id_t RHC      = 8'h13;

    // Fake registers: resolved to constants or side inputs, never stored.
    localparam reg_id_t RNIL     = 8'h80;
    localparam reg_id_t RSYSCALL = 8'h81;
    localparam reg_id_t RV0      = 8'h82;
    localparam reg_id_t RV8      = 8'h83;
    localparam reg_id_t RIP      = 8'h84;
    localparam reg_id_t RIMM     = 8'h85;

endpackage

interface reg_file_rw_if #(
    parameter int DATA_W = 64
);
    logic [7:0]        rd0_id;
    logic [DATA_W+5:0] rd0_val;
    logic              rd0_busy;
    logic [7:0]        rd1_id;
    logic [DATA_W+5:0] rd1_val;
    logic              rd1_busy;
    logic [DATA_W-1:0] rip_val;
    logic [DATA_W-1:0] imm_val;
    logic              wr_en;
    logic [7:0]        wr_id;
    logic [DATA_W+5:0] wr_val;
    logic              mark_en;
    logic [7:0]        mark_id;
    logic              err;
    logic              dump_req;
    logic              dump_valid;
    logic              dump_ready;
    logic [4:0]        dump_idx;
    logic [DATA_W+5:0] dump_val;
    logic              dump_done;

    modport slave (
        input  rd0_id, rd1_id, rip_val, imm_val,
        input  wr_en, wr_id, wr_val, mark_en, mark_id,
        input  dump_req, dump_ready,
        output rd0_val, rd0_busy, rd1_val, rd1_busy, err,
        output dump_valid, dump_idx, dump_val, dump_done
    );

    modport master (
        output rd0_id, rd1_id, rip_val, imm_val,
        output wr_en, wr_id, wr_val, mark_en, mark_id,
        output dump_req, dump_ready,
        input  rd0_val, rd0_busy, rd1_val, rd1_busy, err,
        input  dump_valid, dump_idx, dump_val, dump_done
    );
endinterface

// File: rtl/reg_file_rw.sv
// Architectural register file + busy scoreboard with a handshaked dump stream.
// Latency: reads combinational (write bypass), write/mark at next edge, err one cycle late, dump 2 cycles/entry.
// Backpressure: dump entry held stable in SEND while dump_valid && !dump_ready; other ports never stall.
//
// Ports: clk, reset_n (async active-low); bus (slave modport) carries two read ports
// (id -> val/busy), rip/imm side inputs, write-back, scoreboard mark, err pulse and the dump stream.

module reg_file_rw #(
    parameter int REG_FILE_SIZE = 20,
    parameter int DATA_W        = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    reg_file_rw_if.slave bus
);
    import reg_map_pkg::*;

    localparam int           EW       = DATA_W + 6;
    localparam logic [7:0]   ID_LIMIT = 8'(REG_FILE_SIZE);
    localparam logic [4:0]   LAST_IDX = 5'(REG_FILE_SIZE - 1);

    typedef logic [EW-1:0] ent_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } dump_state_t;

    ent_t                     regs [REG_FILE_SIZE];
    logic [REG_FILE_SIZE-1:0] busy;
    logic                     err_q;

    dump_state_t state, state_nxt;
    logic [4:0]  idx_q, idx_nxt;
    ent_t        dval_q, dval_nxt;
    logic        dvld_q, dvld_nxt;
    logic        done_q, done_nxt;

    function automatic logic id_real(input logic [7:0] id);
        return id < ID_LIMIT;
    endfunction

    function automatic logic id_fake(input logic [7:0] id);
        return (id == RNIL) || (id == RSYSCALL) || (id == RV0) ||
               (id == RV8)  || (id == RIP)      || (id == RIMM);
    endfunction

    // ---------------------------------------------------------------
    // Decode of write-back and mark requests
    // ---------------------------------------------------------------
    logic       wr_real;
    logic [4:0] wr_idx;
    logic       mark_real;
    logic [4:0] mark_idx;
    logic       err_nxt;

    assign wr_real   = bus.wr_en && id_real(bus.wr_id);
    assign wr_idx    = bus.wr_id[4:0];
    assign mark_real = bus.mark_en && id_real(bus.mark_id);
    assign mark_idx  = bus.mark_id[4:0];

    // rnil is a legal "no destination" mark target, so it raises no error.
    assign err_nxt = (bus.wr_en && !id_real(bus.wr_id))
                   || (bus.mark_en && !id_real(bus.mark_id) && (bus.mark_id != RNIL))
                   || (!id_real(bus.rd0_id) && !id_fake(bus.rd0_id))
                   || (!id_real(bus.rd1_id) && !id_fake(bus.rd1_id));

    // ---------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------
    function automatic ent_t resolve(
        input logic [7:0]        id,
        input ent_t              arr_ent,
        input logic              byp,
        input ent_t              byp_val,
        input logic [DATA_W-1:0] rip,
        input logic [DATA_W-1:0] imm
    );
        ent_t r;
        r = '0;
        if (id_real(id)) begin
            r = byp ? byp_val : arr_ent;
        end else begin
            // Fake ids carry no flags; unmapped ids fall to zero.
            case (id)
                RV8:     r[DATA_W-1:0] = DATA_W'(8);
                RIP:     r[DATA_W-1:0] = rip;
                RIMM:    r[DATA_W-1:0] = imm;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    ent_t rd0_arr, rd1_arr;
    logic rd0_byp, rd1_byp;

    always_comb begin
        rd0_arr = '0;
        rd1_arr = '0;
        if (id_real(bus.rd0_id)) rd0_arr = regs[bus.rd0_id[4:0]];
        if (id_real(bus.rd1_id)) rd1_arr = regs[bus.rd1_id[4:0]];
    end

    assign rd0_byp = wr_real && (bus.wr_id == bus.rd0_id);
    assign rd1_byp = wr_real && (bus.wr_id == bus.rd1_id);

    assign bus.rd0_val  = resolve(bus.rd0_id, rd0_arr, rd0_byp, bus.wr_val,
                                  bus.rip_val, bus.imm_val);
    assign bus.rd1_val  = resolve(bus.rd1_id, rd1_arr, rd1_byp, bus.wr_val,
                                  bus.rip_val, bus.imm_val);
    assign bus.rd0_busy = id_real(bus.rd0_id) && busy[bus.rd0_id[4:0]];
    assign bus.rd1_busy = id_real(bus.rd1_id) && busy[bus.rd1_id[4:0]];
    assign bus.err      = err_q;

    // ---------------------------------------------------------------
    // Storage, scoreboard and error pulse
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                regs[i] <= '0;
            end
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_real) begin
                regs[wr_idx] <= bus.wr_val;
            end
            // A mark on the same edge as a write-back wins: the newly issued
            // producer supersedes the one that is completing.
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                if (mark_real && (mark_idx == 5'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wr_real && (wr_idx == 5'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
            err_q <= err_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Dump engine
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            idx_q  <= '0;
            dval_q <= '0;
            dvld_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx_q  <= idx_nxt;
            dval_q <= dval_nxt;
            dvld_q <= dvld_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        dval_nxt  = dval_q;
        dvld_nxt  = dvld_q;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.dump_req) begin
                    idx_nxt   = '0;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // Same-cycle write to this entry is captured, so the dump
                // reflects the value the entry holds after this edge.
                if (wr_real && (wr_idx == idx_q)) begin
                    dval_nxt = bus.wr_val;
                end else begin
                    dval_nxt = regs[idx_q];
                end
                dvld_nxt  = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                // Captured copy is held; later writes do not disturb the beat.
                if (bus.dump_ready) begin
                    dvld_nxt = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx_q + 5'd1;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.dump_valid = dvld_q;
    assign bus.dump_idx   = idx_q;
    assign bus.dump_val   = dval_q;
    assign bus.dump_done  = done_q;

endmodule

// File: doc/reg_file_rw.md
Name: reg_file_rw

Overview:
- Architectural register file and scoreboard, the consumer and resolver of reg_id_t / reg_val_t identifiers from the RegMap package.
- Resolves any reg_id_t (real or fake) to a reg_val_t on two read ports, takes one write-back port, and tracks per-register busy bits for in-flight producers.
- Provides a handshaked dump engine that streams all entries out in index order for end-of-run checking.

Parameters:
- REG_FILE_SIZE, 20, number of real entries. Index = reg_num(id), rax=0 … rhc=19.
- DATA_W, 64, width of reg_val_t.val. The flag bits are cf, zf, sf, of, pf, af (6), so the entry width is DATA_W+6.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock, asynchronous assert, active-low.
- rd0_id  in  8  reg_id_t for read port 0.
- rd0_val  out  70  reg_val_t resolved for rd0_id.
- rd0_busy  out  1  scoreboard busy bit for rd0_id.
- rd1_id, rd1_val, rd1_busy  in/out/out  8/70/1  identical second read port.
- rip_val  in  64  current instruction pointer, returned for rip.
- imm_val  in  64  decoded immediate, returned for rimm.
- wr_en  in  1  write-back strobe.
- wr_id  in  8  write-back destination reg_id_t.
- wr_val  in  70  write-back reg_val_t (flags and value).
- mark_en  in  1  set busy for mark_id (issue of a producer).
- mark_id  in  8  reg_id_t to mark.
- err  out  1  registered one-cycle pulse on an illegal write, mark, or read id.
- dump_req  in  1  start a dump stream.
- dump_valid  out  1  dump entry valid.
- dump_ready  in  1  dump sink accepts.
- dump_idx  out  5  entry index 0..19.
- dump_val  out  70  entry contents.
- dump_done  out  1  one-cycle pulse after the last entry is accepted.

Behaviour:
- Reset (reset_n=0, async): all entries 0, all busy 0, FSM IDLE, dump_valid=0, dump_idx=0, dump_val=0, dump_done=0, err=0.
- Read (combinational, 0 latency):
  - Real id: returns the array entry. If wr_en and wr_id==rd_id in the same cycle, returns wr_val (write bypass).
  - rnil and rsyscall: 0. rv0: val=0. rv8: val=8. rip: val=rip_val. rimm: val=imm_val.
  - Fake ids always have flags=0 and busy=0.
  - Unmapped id (any other encoding): val=0, busy=0, and err pulses the next cycle.
- Write:
  - On a clk edge with wr_en and a real wr_id: the entry takes wr_val (all 70 bits) and its busy bit is cleared.
  - wr_en with a fake or unmapped id: dropped, and err pulses the next cycle.
- Mark:
  - mark_en with a real id sets busy at the edge.
  - Same edge, same id as a write: busy ends 1 (mark wins; the new producer supersedes) and the data is still written.
  - mark_en on rnil: ignored, no err. Any other fake or unmapped id: err.
- Dump FSM (IDLE, LOAD, SEND, DONE):
  - IDLE: dump_req → LOAD with idx=0. dump_req in any other state is ignored.
  - LOAD: captures entry[idx] into dump_val, applying write bypass when wr_id maps to idx that cycle. Sets dump_valid=1 → SEND.
  - SEND: dump_val and dump_idx stay stable while dump_valid && !dump_ready, even if the entry is written meanwhile.
  - SEND, on dump_ready: if idx==REG_FILE_SIZE-1, clear dump_valid → DONE. Otherwise idx+1 → LOAD.
  - DONE: dump_done=1 for one cycle → IDLE.
  - Throughput is 1 entry per 2 cycles. A complete dump with ready tied high takes 40 cycles from the dump_req edge to the dump_done pulse.
- Writes and marks proceed normally during a dump. An entry already sent is not re-sent.
- reset_n asserted mid-dump aborts the stream immediately: dump_valid=0 and no dump_done pulse.

Test Plan:
- Reset, then read rax/rhc/rnil/rv8 → val 0/0/0/8; rip with rip_val=0x401000 → 0x401000; all busy 0.
- mark rbx, next cycle write rbx val=0xDEAD, zf=1 → rd0_busy 1 then 0; same-cycle read of rbx during the write returns 0xDEAD via bypass.
- Same-edge mark_en and wr_en on r12 → r12 data updated and busy=1.
- wr_en to rimm, mark_en to rip, read id 0x9F → three err pulses; the array is unchanged.
- Preload entries with val=index*0x11, then dump with ready tied high → 20 beats, idx 0..19, val 0x00..0x143, dump_done pulse on cycle 40.
- Dump with ready low for 5 cycles at idx 4 while writing rsp=0xFFFF → dump_val holds the old rsp value until accepted. Then assert reset_n low at idx 10 → dump_valid drops, no dump_done.
